// File: rtl/term_pkg.sv
// Shared terminal definitions.
//   DATA_W_DEF : default character cell width
//   BLANK_DEF  : space code written by the clear engine and returned for
//                out-of-range reads
//   clr_state_e: clear engine states
package term_pkg;
  localparam int         DATA_W_DEF = 8;
  localparam logic [7:0] BLANK_DEF  = 8'h20;

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} clr_state_e;
endpackage

// File: rtl/char_ram_dp.sv
// Dual-port character RAM, DEPTH x DATA_W, registered outputs.
//   clk, reset_n   : clock, async active-low reset (output registers only)
//   a_we/a_addr/a_din/a_dout : read/write port (CPU or clear engine)
//   b_addr/b_dout  : read-only port (video scan-out)
// A read that coincides with a write to the same address on port A returns
// the old contents. The array itself is never reset.
module char_ram_dp #(
  parameter int    DEPTH     = 2000,
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_dout_d, a_dout_q, b_dout_d, b_dout_q;

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
  end

  always_comb begin
    a_dout_d = mem[a_addr];
    b_dout_d = mem[b_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  assign a_dout = a_dout_q;
  assign b_dout = b_dout_q;
endmodule

// File: rtl/scroll_char_buffer.sv
// Row/column addressed character store with hardware scroll and clear.
//   clk, reset_n        : clock, async active-low reset
//   cpu_row/col/din/we  : CPU access (writes only while cpu_ready)
//   cpu_ready, cpu_dout : write acceptance, registered read data
//   vid_row/col, vid_dout : scan-out read port, never stalled
//   scroll_up, clear_screen : single-cycle commands, ignored while busy
//   busy, first_row     : clear engine active, physical index of logical row 0
// cpu_dout is only meaningful while cpu_ready=1; during a clear port A is
// owned by the clear engine.
module scroll_char_buffer
  import term_pkg::*;
#(
  parameter int                COLS      = 80,
  parameter int                ROWS      = 25,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] BLANK     = DATA_W'(BLANK_DEF),
  parameter string             INIT_FILE = "",
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int DEPTH  = ROWS * COLS,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ROW_W-1:0]  cpu_row,
  input  logic [COL_W-1:0]  cpu_col,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_we,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic [ROW_W-1:0]  vid_row,
  input  logic [COL_W-1:0]  vid_col,
  output logic [DATA_W-1:0] vid_dout,
  input  logic              scroll_up,
  input  logic              clear_screen,
  output logic              busy,
  output logic [ROW_W-1:0]  first_row
);
  localparam logic [ROW_W:0]    ROWS_X    = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]    COLS_X    = (COL_W+1)'(COLS);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS-1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(DEPTH-1);

  clr_state_e        state_q, state_d;
  logic [ROW_W-1:0]  first_row_q, first_row_d, clr_row_q, clr_row_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              cpu_ok_q, cpu_ok_d, vid_ok_q, vid_ok_d;

  // Logical (row,col) -> flat address. Both operands are < ROWS when in
  // range, so one conditional subtract replaces the modulo.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] base,
                                                  input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    logic [ROW_W:0] sum;
    sum = {1'b0, base} + {1'b0, row};
    if (sum >= ROWS_X) sum = sum - ROWS_X;
    return ADDR_W'(sum[ROW_W-1:0]) * COLS_A + ADDR_W'(col);
  endfunction

  logic [ADDR_W-1:0] cpu_addr, vid_addr, clr_addr, a_addr;
  logic              a_we;
  logic [DATA_W-1:0] a_din, a_dout, b_dout;

  always_comb begin
    cpu_ok_d = ({1'b0, cpu_row} < ROWS_X) && ({1'b0, cpu_col} < COLS_X);
    vid_ok_d = ({1'b0, vid_row} < ROWS_X) && ({1'b0, vid_col} < COLS_X);
    cpu_addr = cell_addr(first_row_q, cpu_row, cpu_col);
    vid_addr = cell_addr(first_row_q, vid_row, vid_col);
    clr_addr = (state_q == CLR_LINE) ? ADDR_W'(clr_row_q) * COLS_A + ptr_q : ptr_q;
    // Port A belongs to the clear engine whenever it runs.
    if (busy_q) begin
      a_we   = 1'b1;
      a_addr = clr_addr;
      a_din  = BLANK;
    end else begin
      a_we   = cpu_we & cpu_ok_d;
      a_addr = cpu_addr;
      a_din  = cpu_din;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    first_row_d = first_row_q;
    clr_row_d   = clr_row_q;
    case (state_q)
      IDLE: begin
        if (clear_screen) begin
          state_d     = CLR_ALL;
          ptr_d       = '0;
          first_row_d = '0;
        end else if (scroll_up) begin
          // Old top row becomes the new bottom row and is blanked.
          clr_row_d   = first_row_q;
          first_row_d = (first_row_q == ROW_LAST) ? '0 : first_row_q + 1'b1;
          ptr_d       = '0;
          state_d     = CLR_LINE;
        end
      end
      CLR_LINE: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LINE_LAST) state_d = IDLE;
      end
      CLR_ALL: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ALL_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      first_row_q <= '0;
      clr_row_q   <= '0;
      busy_q      <= 1'b0;
      cpu_ok_q    <= 1'b1;
      vid_ok_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      first_row_q <= first_row_d;
      clr_row_q   <= clr_row_d;
      busy_q      <= busy_d;
      cpu_ok_q    <= cpu_ok_d;
      vid_ok_q    <= vid_ok_d;
    end
  end

  char_ram_dp #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk(clk), .reset_n(reset_n),
    .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
    .b_addr(vid_addr), .b_dout(b_dout)
  );

  assign cpu_dout  = cpu_ok_q ? a_dout : BLANK;
  assign vid_dout  = vid_ok_q ? b_dout : BLANK;
  assign busy      = busy_q;
  assign cpu_ready = ~busy_q;
  assign first_row = first_row_q;
endmodule

// File: tb/tb_scroll_char_buffer.sv
module tb_scroll_char_buffer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [4:0] cpu_row = '0, vid_row = '0;
  logic [6:0] cpu_col = '0, vid_col = '0;
  logic [7:0] cpu_din = '0;
  logic       cpu_we = 1'b0, scroll_up = 1'b0, clear_screen = 1'b0;
  logic       cpu_ready, busy;
  logic [7:0] cpu_dout, vid_dout;
  logic [4:0] first_row;

  scroll_char_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_row(cpu_row), .cpu_col(cpu_col), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cpu_ready(cpu_ready), .cpu_dout(cpu_dout),
    .vid_row(vid_row), .vid_col(vid_col), .vid_dout(vid_dout),
    .scroll_up(scroll_up), .clear_screen(clear_screen),
    .busy(busy), .first_row(first_row)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  typedef struct {bit cpu; logic [7:0] exp; string nm;} exp_t;
  exp_t sb[$];
  logic rd_req = 1'b0, pend = 1'b0;

  // A read issued before posedge N is presented after N; compare at the
  // following negedge.
  always @(posedge clk) pend <= rd_req;

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] got;
    if (pend) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: read presented with no expectation");
      end else begin
        e   = sb.pop_front();
        got = e.cpu ? cpu_dout : vid_dout;
        if (got !== e.exp) begin
          bad++;
          $display("FAIL %s: got %02h want %02h", e.nm, got, e.exp);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic vid_rd(input int r, input int c, input logic [7:0] e, input string nm);
    vid_row = 5'(r); vid_col = 7'(c); rd_req = 1'b1;
    sb.push_back('{1'b0, e, nm});
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic cpu_rd(input int r, input int c, input logic [7:0] e, input string nm);
    cpu_row = 5'(r); cpu_col = 7'(c); rd_req = 1'b1;
    sb.push_back('{1'b1, e, nm});
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic cpu_wr(input int r, input int c, input logic [7:0] d);
    cpu_row = 5'(r); cpu_col = 7'(c); cpu_din = d; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  // Write while reading the same cell: old data must come back.
  task automatic cpu_wr_rdw(input int r, input int c, input logic [7:0] d, input logic [7:0] old);
    cpu_row = 5'(r); cpu_col = 7'(c); cpu_din = d; cpu_we = 1'b1; rd_req = 1'b1;
    sb.push_back('{1'b1, old, "rdw_old"});
    @(negedge clk);
    cpu_we = 1'b0; rd_req = 1'b0;
  endtask

  // Counts busy cycles; optional action at busy cycle act_at:
  // act 1 = dropped CPU write + video read, act 2 = scroll_up pulse.
  task automatic wait_idle(input int act_at, input int act, output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      if (n == act_at) begin
        if (act == 1) begin
          cpu_row = 5'd5; cpu_col = 7'd5; cpu_din = 8'hAB; cpu_we = 1'b1;
          vid_row = 5'd24; vid_col = 7'd79; rd_req = 1'b1;
          sb.push_back('{1'b0, 8'h66, "vid_during_clear"});
        end else if (act == 2) begin
          scroll_up = 1'b1;
        end
      end
      @(negedge clk);
      cpu_we = 1'b0; rd_req = 1'b0; scroll_up = 1'b0;
    end
    if (n >= 3000) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_scroll(input int exp_fr);
    int n;
    scroll_up = 1'b1;
    @(negedge clk);
    scroll_up = 1'b0;
    check("scroll_first_row", 32'(first_row), 32'(exp_fr));
    wait_idle(0, 0, n);
    check("scroll_busy_cycles", 32'(n), 32'd80);
  endtask

  task automatic sweep(input string nm);
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 80; c++) vid_rd(r, c, 8'h20, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_first_row", 32'(first_row), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_vid_dout", 32'(vid_dout), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic writes, reads, range handling, read-during-write.
    cpu_wr(0, 0, 8'h41);
    cpu_wr(24, 79, 8'h42);
    cpu_wr(1, 0, 8'h10);
    vid_rd(0, 0, 8'h41, "t1_r0c0");
    vid_rd(24, 79, 8'h42, "t1_r24c79");
    vid_rd(25, 0, 8'h20, "t1_row_oob");
    vid_rd(0, 80, 8'h20, "t1_col_oob");
    cpu_rd(24, 79, 8'h42, "t1_cpu_rd");
    cpu_rd(31, 127, 8'h20, "t1_cpu_oob");
    cpu_wr(25, 0, 8'h77);   // would alias to (0,0) if not dropped
    cpu_wr(0, 80, 8'h78);   // would alias to (1,0) if not dropped
    vid_rd(0, 0, 8'h41, "t1_oob_row_wr");
    vid_rd(1, 0, 8'h10, "t1_oob_col_wr");
    cpu_wr(3, 3, 8'h11);
    cpu_wr_rdw(3, 3, 8'h22, 8'h11);
    cpu_rd(3, 3, 8'h22, "rdw_new");

    // Scroll with a coincident CPU write using the old mapping.
    cpu_wr(1, 5, 8'h58);
    cpu_row = 5'd2; cpu_col = 7'd7; cpu_din = 8'h77; cpu_we = 1'b1; scroll_up = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0; scroll_up = 1'b0;
    check("t2_first_row", 32'(first_row), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_ready", 32'(cpu_ready), 32'd0);
    wait_idle(0, 0, n);
    check("t2_busy_cycles", 32'(n), 32'd80);
    vid_rd(0, 5, 8'h58, "t2_r0c5");
    vid_rd(0, 0, 8'h10, "t2_r0c0");
    vid_rd(1, 7, 8'h77, "t2_coincident_wr");
    vid_rd(23, 79, 8'h42, "t2_r23c79");
    for (int c = 0; c < 80; c++) vid_rd(24, c, 8'h20, "t2_bottom_blank");

    // 24 more scrolls: first_row wraps back to 0, every line blanked.
    for (int i = 1; i <= 24; i++) do_scroll((1 + i) % 25);
    check("t3_wrap", 32'(first_row), 32'd0);
    sweep("t3_sweep");

    // Clear screen after 3 scrolls.
    for (int i = 1; i <= 3; i++) do_scroll(i);
    cpu_wr(21, 79, 8'h66);   // physical row 24, last cell cleared
    vid_rd(21, 79, 8'h66, "t4_pre_clear");
    clear_screen = 1'b1;
    @(negedge clk);
    clear_screen = 1'b0;
    check("t4_first_row", 32'(first_row), 32'd0);
    wait_idle(1900, 1, n);
    check("t4_busy_cycles", 32'(n), 32'd2000);
    sweep("t4_sweep");

    // Simultaneous commands: clear wins; scroll mid-clear ignored.
    do_scroll(1);
    do_scroll(2);
    cpu_wr(7, 7, 8'h55);
    scroll_up = 1'b1; clear_screen = 1'b1;
    @(negedge clk);
    scroll_up = 1'b0; clear_screen = 1'b0;
    check("t5_first_row", 32'(first_row), 32'd0);
    wait_idle(1000, 2, n);
    check("t5_busy_cycles", 32'(n), 32'd2000);
    check("t5_first_row_end", 32'(first_row), 32'd0);
    @(negedge clk);
    check("t5_not_queued", 32'(busy), 32'd0);
    vid_rd(9, 7, 8'h20, "t5_cleared");

    // Reset 500 cycles into a full clear.
    cpu_wr(0, 10, 8'h31);
    cpu_wr(10, 0, 8'h32);
    cpu_wr(24, 79, 8'h33);
    cpu_wr(6, 19, 8'h34);
    cpu_wr(6, 20, 8'h35);
    clear_screen = 1'b1;
    @(negedge clk);
    clear_screen = 1'b0;
    repeat (500) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_first_row", 32'(first_row), 32'd0);
    check("t6_ready", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vid_rd(0, 10, 8'h20, "t6_addr10");
    vid_rd(6, 19, 8'h20, "t6_addr499");
    vid_rd(6, 20, 8'h35, "t6_addr500");
    vid_rd(10, 0, 8'h32, "t6_addr800");
    vid_rd(24, 79, 8'h33, "t6_addr1999");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
